// File: rtl/datapath_pkg.sv
// datapath_pkg: shared ALU function codes, data-bus source codes, FSM states and index-width helper
package datapath_pkg;

    typedef enum logic [2:0] {
        F_NEG  = 3'd0,
        F_SUB  = 3'd1,
        F_ADD  = 3'd2,
        F_MULH = 3'd3,
        F_MULL = 3'd4,
        F_XOR  = 3'd5,
        F_AND  = 3'd6,
        F_NOT  = 3'd7
    } alu_op_e;

    localparam logic [3:0] SRC_X    = 4'd0;
    localparam logic [3:0] SRC_Y    = 4'd1;
    localparam logic [3:0] SRC_R    = 4'd2;
    localparam logic [3:0] SRC_M    = 4'd3;
    localparam logic [3:0] SRC_I    = 4'd4;
    localparam logic [3:0] SRC_DM   = 4'd5;
    localparam logic [3:0] SRC_PM   = 4'd6;
    localparam logic [3:0] SRC_PINS = 4'd7;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    function automatic int idx_w(int x, int y);
        int mx;
        mx = (x > y) ? x : y;
        return ($clog2(mx) > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per cycle; product is valid while done is high
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;

    assign product = r_acc + (r_b[0] ? r_a : '0);
    assign done    = busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            busy  <= 1'b0;
        end else if (start && !busy) begin
            r_acc <= '0;
            r_a   <= {{WIDTH{1'b0}}, a};
            r_b   <= b;
            r_cnt <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            r_acc <= product;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            busy  <= !done;
        end
    end

endmodule

// File: rtl/datapath_gen2.sv
// datapath_gen2: register file, source-selected data bus and ALU with sequential multiplier
module datapath_gen2 import datapath_pkg::*; #(
    parameter int WIDTH  = 4,
    parameter int X_REGS = 2,
    parameter int Y_REGS = 2,
    localparam int IDXW  = idx_w(X_REGS, Y_REGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       source_sel,
    input  logic [IDXW-1:0]  src_idx,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic             x_we,
    input  logic             y_we,
    input  logic             m_we,
    input  logic             o_we,
    input  logic             i_we,
    input  logic             i_sel,
    input  logic [IDXW-1:0]  x_sel,
    input  logic [IDXW-1:0]  y_sel,
    input  logic [3:0]       alu_op,
    input  logic             alu_start,
    input  logic [WIDTH-1:0] pm_data,
    input  logic [WIDTH-1:0] dm,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] data_bus,
    output logic [WIDTH-1:0] o_reg,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] r,
    output logic             r_eq_0,
    output logic             r_carry,
    output logic             alu_busy,
    output logic             alu_done
);
    logic [WIDTH-1:0]   r_x [X_REGS];
    logic [WIDTH-1:0]   r_y [Y_REGS];
    state_e             r_state;
    logic               r_op_hi;
    alu_op_e            w_func;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic [WIDTH:0]     w_alu;
    logic [WIDTH:0]     w_mul_r;
    logic [WIDTH:0]     w_res;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_is_mul;
    logic               w_accept;
    logic               w_mul_done;
    logic               w_wr_r;

    function automatic logic [WIDTH-1:0] rdx(logic [IDXW-1:0] k);
        return (32'(k) < X_REGS) ? r_x[k] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] rdy(logic [IDXW-1:0] k);
        return (32'(k) < Y_REGS) ? r_y[k] : '0;
    endfunction

    assign w_func   = alu_op_e'(alu_op[2:0]);
    assign w_x      = rdx(x_sel);
    assign w_y      = rdy(y_sel);
    assign w_is_mul = (w_func == F_MULH) || (w_func == F_MULL);
    assign w_accept = alu_start && !alu_busy;
    assign w_wr_r   = (r_state == S_IDLE) ? (w_accept && !w_is_mul) : w_mul_done;
    assign w_mul_r  = r_op_hi ? {|w_prod[WIDTH-1:0], w_prod[2*WIDTH-1:WIDTH]}
                              : {|w_prod[2*WIDTH-1:WIDTH], w_prod[WIDTH-1:0]};
    assign w_res    = (r_state == S_MUL) ? w_mul_r : w_alu;

    always_comb begin
        case (source_sel)
            SRC_X:    data_bus = rdx(src_idx);
            SRC_Y:    data_bus = rdy(src_idx);
            SRC_R:    data_bus = r;
            SRC_M:    data_bus = m;
            SRC_I:    data_bus = i;
            SRC_DM:   data_bus = dm;
            SRC_PM:   data_bus = pm_data;
            SRC_PINS: data_bus = i_pins;
            default:  data_bus = '0;
        endcase
    end

    // MSB of w_alu is the carry/borrow flag
    always_comb begin
        case (w_func)
            F_NEG:   w_alu = alu_op[3] ? {1'b0, r} : {1'b0, -w_x};
            F_SUB:   w_alu = {1'b0, w_x} - {1'b0, w_y};
            F_ADD:   w_alu = {1'b0, w_x} + {1'b0, w_y};
            F_XOR:   w_alu = {1'b0, w_x ^ w_y};
            F_AND:   w_alu = {1'b0, w_x & w_y};
            F_NOT:   w_alu = alu_op[3] ? {1'b0, r} : {1'b0, ~w_x};
            default: w_alu = '0;
        endcase
    end

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_accept && w_is_mul),
        .a       (w_x),
        .b       (w_y),
        .busy    (alu_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op_hi  <= 1'b0;
            r        <= '0;
            r_carry  <= 1'b0;
            r_eq_0   <= 1'b1;
            alu_done <= 1'b0;
        end else begin
            alu_done <= w_wr_r;
            if (w_wr_r) begin
                r       <= w_res[WIDTH-1:0];
                r_carry <= w_res[WIDTH];
                r_eq_0  <= (w_res[WIDTH-1:0] == '0);
            end
            if (r_state == S_IDLE && w_accept && w_is_mul) begin
                r_state <= S_MUL;
                r_op_hi <= (w_func == F_MULH);
            end else if (r_state == S_MUL && w_mul_done) begin
                r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < X_REGS; k++) r_x[k] <= '0;
            for (int k = 0; k < Y_REGS; k++) r_y[k] <= '0;
            m     <= '0;
            o_reg <= '0;
            i     <= '0;
        end else begin
            for (int k = 0; k < X_REGS; k++) if (x_we && 32'(wr_idx) == k) r_x[k] <= data_bus;
            for (int k = 0; k < Y_REGS; k++) if (y_we && 32'(wr_idx) == k) r_y[k] <= data_bus;
            if (m_we) m <= data_bus;
            if (o_we) o_reg <= data_bus;
            if (i_we) i <= i_sel ? i + m : data_bus;
        end
    end

endmodule

// File: doc/datapath_gen2.md
# datapath_gen2

Parametrised successor to the 4-bit CPU datapath. It holds a register file and operand, index, mask and output registers, a source-selected data bus and an ALU. It adds configurable data width and X/Y register count, a multi-cycle shift-add multiplier with a start/busy/done handshake, and a carry flag alongside r_eq_0. The control unit drives it one micro-operation per cycle.

## Interface
- WIDTH, 4, data width in bits; must be ≥ 2.
- X_REGS, 2, number of X registers; must be ≥ 1.
- Y_REGS, 2, number of Y registers; must be ≥ 1.
- IDXW (localparam), max(1, $clog2(max(X_REGS, Y_REGS))).
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- source_sel  in  4  data_bus source: 0 x[src_idx], 1 y[src_idx], 2 r, 3 m, 4 i, 5 dm, 6 pm_data, 7 i_pins; 8–15 drive zero.
- src_idx  in  IDXW  register index for sources 0 and 1.
- wr_idx  in  IDXW  destination index for x_we and y_we.
- x_we, y_we, m_we, o_we  in  1 each  load data_bus into x[wr_idx], y[wr_idx], m, o_reg.
- i_we  in  1  load i.
- i_sel  in  1  i source when i_we=1: 1 gives i+m, 0 gives data_bus.
- x_sel, y_sel  in  IDXW each  ALU operand indices.
- alu_op  in  4  {ir3, func[2:0]}; encoding under Operation.
- alu_start  in  1  request an ALU operation.
- pm_data, dm, i_pins  in  WIDTH each  immediate, data-memory and pin inputs.
- data_bus  out  WIDTH  combinational source mux.
- o_reg, i, m, r  out  WIDTH each  registers.
- r_eq_0, r_carry  out  1 each  flags, written together with r.
- alu_busy  out  1  multiply in progress.
- alu_done  out  1  one-cycle pulse when r is written.

## Operation
- Out-of-range indices (≥ X_REGS or ≥ Y_REGS):
  - read as zero;
  - writes are dropped.
- Register writes from data_bus are independent of the ALU and allowed while busy. Simultaneous enables all take effect.
- i+m wraps modulo 2^WIDTH.
- ALU func codes; operands are X = x[x_sel], Y = y[y_sel]:
  - 000 with ir3=0: −X. With ir3=1: pass r.
  - 001: X−Y; r_carry = borrow.
  - 010: X+Y; r_carry = carry-out.
  - 011: high half of X*Y.
  - 100: low half of X*Y.
  - 101: X^Y.
  - 110: X&Y.
  - 111 with ir3=0: ~X. With ir3=1: pass r.
- r_carry for other ops:
  - 011/100: OR-reduce of the discarded product half.
  - All other ops: 0.
- r_eq_0 = (value written to r == 0).
- Accept: alu_start=1 sampled with alu_busy=0. alu_start while busy is ignored; it is neither queued nor aborts.
- FSM IDLE → MUL → IDLE:
  - Single-cycle ops: r and flags are written on the accept edge; stay IDLE.
  - 011/100: X, Y and the op are latched on the accept edge; go to MUL with a counter at 0.
  - In MUL, one shift-add iteration per edge. On iteration WIDTH, r and flags are written and the FSM returns to IDLE.
- alu_done is registered: high for exactly the one cycle after the edge that writes r.

## Timing
- Reset values (asynchronous, immediate): every register, r, i, m, o_reg, r_carry, alu_busy and alu_done are 0; r_eq_0 is 1; FSM is IDLE.
- Single-cycle op accepted at edge E0: r valid and alu_done=1 in the cycle after E0.
- Multiply accepted at edge E0:
  - alu_busy=1 from E0 up to E_WIDTH;
  - r valid and alu_done=1 in the cycle after E_WIDTH;
  - alu_busy=0 in that same cycle, so a new start is accepted at E_WIDTH+1. Back-to-back throughput is one multiply per WIDTH+1 cycles.
- Operand registers written during MUL do not affect the in-flight result.
- Reset asserted mid-multiply: aborts, no alu_done, r=0.
- data_bus has zero latency from source_sel and its sources.

## Structure
- Package datapath_pkg:
  - alu_op enum;
  - source_sel constants;
  - FSM state typedef.
- Sub-module seq_multiplier, parametrised by WIDTH:
  - ports clk, reset_n, start, a, b, busy, done, product[2*WIDTH-1:0];
  - the datapath instantiates it and selects the product half.

## Test plan
- Reset → o_reg, i, m, r, every x/y register, r_carry, alu_busy and alu_done = 0; r_eq_0 = 1. source_sel=0xA → data_bus = 0.
- WIDTH=4: x0=9, y0=8, op 010, start → next cycle r=1, r_carry=1, r_eq_0=0, alu_done=1 for one cycle.
- WIDTH=4: x0=0xF, y0=0xF, op 011, start → alu_busy 4 cycles, then r=0xE, r_carry=1. A second start at cycle 2 is ignored, with exactly one alu_done.
- Multiply 3*5 (op 100) with x0 overwritten to 0 during busy → r=0xF, r_carry=0.
- reset_n low at cycle 2 of a multiply → alu_busy=0, r=0, no alu_done. A later start works normally.
- i=0xE, m=3, i_we=1, i_sel=1 → i=0x1. WIDTH=8 build: 200+100 → r=44, r_carry=1.
